// File: rtl/gh_pkg.sv
// Shared types and constants for the guitar-lane note scoring logic.
package gh_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPROACH,
    WINDOW,
    GRACE
  } lane_state_t;

  localparam int unsigned MULT_W   = 3;
  localparam int unsigned MULT_T1  = 10;
  localparam int unsigned MULT_T2  = 20;
  localparam int unsigned MULT_T3  = 30;
  localparam int unsigned MULT_MAX = 4;

  // Multiplier from the current combo streak: 1 below T1, stepping up to MULT_MAX.
  function automatic logic [MULT_W-1:0] mult_of(input int unsigned combo);
    logic [MULT_W-1:0] m;
    if (combo >= MULT_T3)      m = MULT_W'(MULT_MAX);
    else if (combo >= MULT_T2) m = MULT_W'(3);
    else if (combo >= MULT_T1) m = MULT_W'(2);
    else                       m = MULT_W'(1);
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing the approach and window phases of a note.
module phase_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/hit_window_scorer.sv
// Per-lane note timing FSM: opens the hit window, resolves hit/miss and keeps score/combo.
module hit_window_scorer
  import gh_pkg::*;
#(
  parameter int unsigned APPROACH_CYCLES = 1000,
  parameter int unsigned WINDOW_CYCLES   = 200,
  parameter int unsigned POINTS          = 10,
  parameter int unsigned SCORE_W         = 16,
  parameter int unsigned COMBO_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               note_strobe,
  input  logic               hit_in,
  output logic               hit_window,
  output logic               hit_ok,
  output logic               miss,
  output logic               note_drop,
  output logic               busy,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [MULT_W-1:0]  mult
);

  localparam int unsigned CNT_MAX = (APPROACH_CYCLES > WINDOW_CYCLES) ? APPROACH_CYCLES
                                                                      : WINDOW_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned SUM_W   = SCORE_W + 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [COMBO_W-1:0] COMBO_MAX = {COMBO_W{1'b1}};

  lane_state_t        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d, score_hit;
  logic [COMBO_W-1:0] combo_q, combo_d, combo_hit;
  logic               hit_ok_q, hit_ok_d;
  logic               miss_q, miss_d;
  logic               note_drop_q, note_drop_d;
  logic [SUM_W-1:0]   score_sum;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_dec;
  logic               tmr_zero;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_c     (tmr_zero)
  );

  // Saturating score/combo values a hit would produce, using the pre-hit multiplier.
  always_comb begin
    score_sum = SUM_W'(score_q) + SUM_W'(POINTS) * SUM_W'(mult);
    score_hit = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(score_sum);
    combo_hit = (combo_q == COMBO_MAX) ? combo_q : combo_q + COMBO_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    combo_d     = combo_q;
    hit_ok_d    = 1'b0;
    miss_d      = 1'b0;
    note_drop_d = note_strobe && (state_q != IDLE);
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (note_strobe) begin
          state_d  = APPROACH;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(APPROACH_CYCLES - 1);
        end
      end
      APPROACH: begin
        if (tmr_zero) begin
          state_d  = WINDOW;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(WINDOW_CYCLES - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      WINDOW: begin
        // A hit on the last window cycle wins over the move to GRACE.
        if (hit_in) begin
          state_d  = IDLE;
          score_d  = score_hit;
          combo_d  = combo_hit;
          hit_ok_d = 1'b1;
        end else if (tmr_zero) begin
          state_d = GRACE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      GRACE: begin
        state_d = IDLE;
        if (hit_in) begin
          score_d  = score_hit;
          combo_d  = combo_hit;
          hit_ok_d = 1'b1;
        end else begin
          combo_d = '0;
          miss_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      score_q     <= '0;
      combo_q     <= '0;
      hit_ok_q    <= 1'b0;
      miss_q      <= 1'b0;
      note_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      hit_ok_q    <= hit_ok_d;
      miss_q      <= miss_d;
      note_drop_q <= note_drop_d;
    end
  end

  assign hit_window = (state_q == WINDOW);
  assign busy       = (state_q != IDLE);
  assign hit_ok     = hit_ok_q;
  assign miss       = miss_q;
  assign note_drop  = note_drop_q;
  assign score      = score_q;
  assign combo      = combo_q;
  assign mult       = mult_of(32'(combo_q));

endmodule

// File: doc/hit_window_scorer.md
# hit_window_scorer

Note-timing and scoring engine for one guitar lane. It tracks each spawned note while it travels down the highway, then drives the lane's hit-window signal into the button controller FSM. It consumes that controller's one-cycle hit pulse and resolves every note as a hit or a miss, while maintaining the score, the combo streak and the multiplier that the display logic reads.

## Interface
- `APPROACH_CYCLES`, 1000: cycles from note spawn to window open (≥1).
- `WINDOW_CYCLES`, 200: cycles the hit window stays open (≥1).
- `POINTS`, 10: base points per hit.
- `SCORE_W`, 16: score width.
- `COMBO_W`, 8: combo counter width.
- `clk`  in  1: system clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `note_strobe`  in  1: single-cycle pulse; a note spawns at the top of the highway.
- `hit_in`  in  1: single-cycle hit pulse from the controller FSM. It lags `hit_window` by one cycle.
- `hit_window`  out  1: high while the note is hittable; drives the controller's `time` input.
- `hit_ok`  out  1: one-cycle pulse, note resolved as a hit.
- `miss`  out  1: one-cycle pulse, note resolved as a miss.
- `note_drop`  out  1: one-cycle pulse, a spawn was rejected because a note is already in flight.
- `busy`  out  1: a note is in flight (state ≠ IDLE).
- `score`  out  SCORE_W: accumulated score.
- `combo`  out  COMBO_W: consecutive hits.
- `mult`  out  3: current multiplier, 1–4.

## Operation
- FSM states: IDLE, APPROACH, WINDOW, GRACE. Only one note is in flight at a time.
- IDLE → APPROACH on `note_strobe`. The phase counter loads APPROACH_CYCLES−1.
- APPROACH: the counter decrements every cycle. At 0 → WINDOW, and the counter loads WINDOW_CYCLES−1.
- WINDOW: `hit_window`=1. At counter 0 → GRACE. If `hit_in`=1 → resolve hit and go to IDLE.
- GRACE: lasts exactly 1 cycle, with `hit_window`=0. It absorbs the controller's one-cycle registered latency.
  - If `hit_in`=1 → resolve hit.
  - Otherwise → resolve miss.
  - Either way → IDLE.
- `hit_in` in IDLE or APPROACH is ignored, with no output effect.
- Hit resolution:
  - `score` += POINTS×`mult`, using the `mult` value before the combo increments. Saturates at 2^SCORE_W−1.
  - `combo` += 1, saturating at all-ones.
  - `hit_ok` pulses.
- Miss resolution: `combo` is set to 0, `score` is unchanged, and `miss` pulses.
- `mult` is a combinational decode of the registered `combo`:
  - 0–9 → 1
  - 10–19 → 2
  - 20–29 → 3
  - ≥30 → 4
- A `note_strobe` in any non-IDLE state, including the resolving cycle, is discarded and pulses `note_drop` on the next cycle.
- Reset values:
  - state IDLE, counter 0.
  - `score` 0, `combo` 0, so `mult` = 1.
  - `hit_window`, `hit_ok`, `miss`, `note_drop`, `busy` all 0.
- An asserted `reset` aborts an in-flight note immediately, with no `miss` pulse.

## Timing
- Let E0 be the edge where `note_strobe` is sampled in IDLE.
  - `busy` is high from E0 through the resolving edge.
  - `hit_window` rises at E0+APPROACH_CYCLES and stays high for exactly WINDOW_CYCLES cycles.
  - GRACE is the single following cycle.
- Hit latency: `hit_ok`, `score` and `combo` update on the edge that samples `hit_in`, and `hit_ok` is high for that one cycle.
- Miss: the `miss` pulse and the combo clear occur at the edge that ends GRACE.
- `hit_window`, `busy`, `hit_ok`, `miss` and `note_drop` are glitch-free, being registered or a decode of registered state only.
- A new note is accepted on the first edge after the resolving edge, i.e. the earliest next spawn is 1 cycle later.

## Structure
- Shared package `gh_pkg`:
  - state enum `lane_state_t`.
  - multiplier thresholds (10/20/30) and max multiplier (4).
  - `MULT_W` = 3.
- Sub-module `phase_timer`: a loadable down-counter with a `zero` flag, sized with `$clog2(max(APPROACH_CYCLES, WINDOW_CYCLES))`.
- The top level holds the FSM, the score/combo registers and the pulse registers.

## Test plan
All scenarios use APPROACH_CYCLES=4, WINDOW_CYCLES=3, POINTS=10, unless stated otherwise.
- Strobe at E0, no hit:
  - `hit_window` high at E4–E6, with no hit during that time.
  - `miss` pulses after E7, `combo` stays 0, `score` stays 0.
- Strobe, `hit_in` at the second window cycle:
  - `hit_ok` pulses, `score`=10, `combo`=1.
  - `busy` falls.
  - `hit_window` drops immediately.
- `hit_in` in the GRACE cycle → counts as a hit (`score`=10). `hit_in` one cycle later → ignored, and `miss` is reported.
- Ten consecutive hits, then an eleventh:
  - `score` = 100 + 20 = 120, `combo`=11, `mult`=2.
  - A following miss → `combo`=0, `mult`=1, `score` stays 120.
- Second `note_strobe` during APPROACH, or on the resolving edge → `note_drop` pulses, and only one window is generated.
- `reset` asserted mid-WINDOW:
  - outputs go to 0 asynchronously, `mult`=1.
  - no `miss` pulse.
  - after release, a new strobe behaves as in the first scenario.
- With SCORE_W=8 and the score preloaded near the top via hits, further hits saturate `score` at 255.
